// File: rtl/mc68k_bus_target.sv
// mc68k_bus_target: 68000 bus target decoding a 16-byte window at BASE_ADDR and
// exposing eight 16-bit registers (0..6 read/write, 7 read-only ID 16'h5016).
// Optional feature macro: MC68K_TARGET_BERR_EN -- when defined, a bus write to
// register 7 is answered with BERR instead of DTACK.
module mc68k_bus_target #(
  parameter logic [23:0] BASE_ADDR   = 24'hE90000,
  parameter int unsigned DTACK_DELAY = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [23:1] A_IN,
  input  logic [15:0] D_IN,
  input  logic        RnW_IN,
  input  logic        nAS_IN,
  input  logic        nUDS_IN,
  input  logic        nLDS_IN,
  output logic [15:0] D_OUT,
  output logic [15:0] D_OE,
  output logic        nDTACK_OE,
  output logic        nBERR_OE,
  input  logic [2:0]  host_addr,
  output logic [15:0] host_rdata,
  output logic        wr_strobe,
  output logic [2:0]  wr_index
);

  localparam logic [15:0] REG7_VALUE = 16'h5016;
  localparam logic [3:0]  DELAY_LOAD = 4'(DTACK_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_DELAY,
    S_ACK,
    S_RELEASE
  } state_t;

  logic [23:1] r_aMeta,   r_aSync;
  logic [15:0] r_dMeta,   r_dSync;
  logic        r_rnwMeta, r_rnwSync;
  logic        r_nAsMeta, r_nAsSync;
  logic        r_nUdsMeta, r_nUdsSync;
  logic        r_nLdsMeta, r_nLdsSync;

  state_t      r_state;
  logic [2:0]  r_addrIdx;
  logic        r_rnw;
  logic        r_uds;
  logic        r_lds;
  logic [2:0]  r_index;
  logic [3:0]  r_count;
  logic [1:0]  r_settle;
  logic        r_armed;
  logic [15:0] r_regs [0:7];
  logic [15:0] r_dOut;
  logic [15:0] r_dOe;
  logic        r_dtack;
  logic        r_wrStrobe;
  logic [2:0]  r_wrIndex;
`ifdef MC68K_TARGET_BERR_EN
  logic        r_berr;
`endif

  logic        w_match;
  logic        w_dsActive;
  logic        w_busIdle;
  logic [15:0] w_regRead;
  logic        w_reg7Write;

  assign w_match     = (r_aSync[23:4] == BASE_ADDR[23:4]);
  assign w_dsActive  = ~r_nUdsSync | ~r_nLdsSync;
  assign w_busIdle   = r_nAsSync & r_nUdsSync & r_nLdsSync;
  assign w_regRead   = (r_index == 3'd7) ? REG7_VALUE : r_regs[r_index];
  assign w_reg7Write = ~r_rnw & (r_index == 3'd7);

  // Register 7 is a constant; the storage slot behind it is never written.
  assign host_rdata = (host_addr == 3'd7) ? REG7_VALUE : r_regs[host_addr];

  assign D_OUT     = r_dOut;
  assign D_OE      = r_dOe;
  assign nDTACK_OE = r_dtack;
  assign wr_strobe = r_wrStrobe;
  assign wr_index  = r_wrIndex;
`ifdef MC68K_TARGET_BERR_EN
  assign nBERR_OE  = r_berr;
`else
  assign nBERR_OE  = 1'b0;
`endif

  // Two-flop synchronizers for every bus input; strobes idle high out of reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_aMeta    <= '0;
      r_aSync    <= '0;
      r_dMeta    <= '0;
      r_dSync    <= '0;
      r_rnwMeta  <= 1'b0;
      r_rnwSync  <= 1'b0;
      r_nAsMeta  <= 1'b1;
      r_nAsSync  <= 1'b1;
      r_nUdsMeta <= 1'b1;
      r_nUdsSync <= 1'b1;
      r_nLdsMeta <= 1'b1;
      r_nLdsSync <= 1'b1;
    end else begin
      r_aMeta    <= A_IN;
      r_aSync    <= r_aMeta;
      r_dMeta    <= D_IN;
      r_dSync    <= r_dMeta;
      r_rnwMeta  <= RnW_IN;
      r_rnwSync  <= r_rnwMeta;
      r_nAsMeta  <= nAS_IN;
      r_nAsSync  <= r_nAsMeta;
      r_nUdsMeta <= nUDS_IN;
      r_nUdsSync <= r_nUdsMeta;
      r_nLdsMeta <= nLDS_IN;
      r_nLdsSync <= r_nLdsMeta;
    end
  end

  // Bus cycle FSM: decode, delay, perform access, hold acknowledge until strobes negate.
  // After reset the synchronizers need two cycles to show real pin levels
  // (r_settle), and no cycle is accepted until nAS has been seen high (r_armed),
  // so a cycle already in flight at reset is routed to RELEASE and dropped.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_addrIdx  <= '0;
      r_rnw      <= 1'b0;
      r_uds      <= 1'b0;
      r_lds      <= 1'b0;
      r_index    <= '0;
      r_count    <= '0;
      r_settle   <= '0;
      r_armed    <= 1'b0;
      r_dOut     <= '0;
      r_dOe      <= '0;
      r_dtack    <= 1'b0;
      r_wrStrobe <= 1'b0;
      r_wrIndex  <= '0;
`ifdef MC68K_TARGET_BERR_EN
      r_berr     <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wrStrobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_settle != 2'd2) begin
            r_settle <= r_settle + 2'd1;
          end else if (!r_armed) begin
            if (r_nAsSync) begin
              r_armed <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
            end
          end else if (!r_nAsSync && w_dsActive) begin
            r_addrIdx <= r_aSync[3:1];
            r_rnw     <= r_rnwSync;
            r_uds     <= ~r_nUdsSync;
            r_lds     <= ~r_nLdsSync;
            r_state   <= w_match ? S_ACCEPT : S_RELEASE;
          end
        end

        S_ACCEPT: begin
          r_count <= DELAY_LOAD;
          r_index <= r_addrIdx;
          r_state <= S_DELAY;
        end

        S_DELAY: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_state <= S_ACK;
            if (r_rnw) begin
              r_dOut <= w_regRead;
              r_dOe  <= {{8{r_uds}}, {8{r_lds}}};
            end else if (!w_reg7Write) begin
              if (r_uds) begin
                r_regs[r_index][15:8] <= r_dSync[15:8];
              end
              if (r_lds) begin
                r_regs[r_index][7:0] <= r_dSync[7:0];
              end
              r_wrStrobe <= 1'b1;
              r_wrIndex  <= r_index;
            end
`ifdef MC68K_TARGET_BERR_EN
            if (w_reg7Write) begin
              r_berr <= 1'b1;
            end else begin
              r_dtack <= 1'b1;
            end
`else
            r_dtack <= 1'b1;
`endif
          end
        end

        S_ACK: begin
          if (w_busIdle) begin
            r_dtack <= 1'b0;
            r_dOe   <= '0;
`ifdef MC68K_TARGET_BERR_EN
            r_berr  <= 1'b0;
`endif
            r_state <= S_IDLE;
          end
        end

        S_RELEASE: begin
          if (r_nAsSync) begin
            r_armed <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc68k_bus_target.sv
// tb_mc68k_bus_target: directed bus cycles against mc68k_bus_target with a
// scoreboard of expected register / read-data results.
module tb_mc68k_bus_target;

  localparam logic [23:0] BASE = 24'hE90000;
  localparam int DLY = 2;
  localparam int ACK_LAT = 3 + DLY + 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [23:1] A_IN;
  logic [15:0] D_IN;
  logic        RnW_IN;
  logic        nAS_IN;
  logic        nUDS_IN;
  logic        nLDS_IN;
  logic [15:0] D_OUT;
  logic [15:0] D_OE;
  logic        nDTACK_OE;
  logic        nBERR_OE;
  logic [2:0]  host_addr;
  logic [15:0] host_rdata;
  logic        wr_strobe;
  logic [2:0]  wr_index;

  mc68k_bus_target #(
    .BASE_ADDR  (BASE),
    .DTACK_DELAY(DLY)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .A_IN      (A_IN),
    .D_IN      (D_IN),
    .RnW_IN    (RnW_IN),
    .nAS_IN    (nAS_IN),
    .nUDS_IN   (nUDS_IN),
    .nLDS_IN   (nLDS_IN),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .nDTACK_OE (nDTACK_OE),
    .nBERR_OE  (nBERR_OE),
    .host_addr (host_addr),
    .host_rdata(host_rdata),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index)
  );

  always #5 sys_clk = ~sys_clk;

  int passCount   = 0;
  int failCount   = 0;
  int checkCount  = 0;
  int strobeCount = 0;

  logic [15:0] model [0:7];

  typedef struct {
    logic        isRead;
    logic [2:0]  idx;
    logic [15:0] data;
    logic [15:0] oe;
  } exp_t;

  exp_t sbq[$];

  // Count every cycle in which the write strobe is seen high.
  always @(negedge sys_clk) begin
    if (wr_strobe === 1'b1) strobeCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBus(input logic [23:0] addr, input logic rnw, input logic uds, input logic lds,
                          input logic [15:0] data);
    @(negedge sys_clk);
    A_IN    = addr[23:1];
    D_IN    = data;
    RnW_IN  = rnw;
    nUDS_IN = ~uds;
    nLDS_IN = ~lds;
    nAS_IN  = 1'b0;
  endtask

  task automatic negateBus();
    @(negedge sys_clk);
    nAS_IN  = 1'b1;
    nUDS_IN = 1'b1;
    nLDS_IN = 1'b1;
  endtask

  task automatic applyStimulus(input logic [23:0] addr, input logic rnw, input logic uds, input logic lds,
                               input logic [15:0] data);
    exp_t e;
    logic [2:0] idx;
    idx = addr[3:1];
    driveBus(addr, rnw, uds, lds, data);
    if (addr[23:4] == BASE[23:4] && (rnw || idx != 3'd7)) begin
      if (!rnw) begin
        if (uds) model[idx][15:8] = data[15:8];
        if (lds) model[idx][7:0]  = data[7:0];
      end
      e.isRead = rnw;
      e.idx    = idx;
      e.data   = model[idx];
      e.oe     = {{8{uds}}, {8{lds}}};
      sbq.push_back(e);
    end
  endtask

  task automatic waitAck(output int cycles, output logic [15:0] hostBefore);
    cycles     = 0;
    hostBefore = host_rdata;
    while (cycles < 40 && !(nDTACK_OE || nBERR_OE)) begin
      hostBefore = host_rdata;
      @(negedge sys_clk);
      cycles++;
    end
  endtask

  task automatic popCheck(input string tag);
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.isRead) begin
        checkOutput({tag, "_dout"}, 32'(D_OUT), 32'(e.data));
        checkOutput({tag, "_doe"}, 32'(D_OE), 32'(e.oe));
      end else begin
        host_addr = e.idx;
        #1;
        checkOutput({tag, "_reg"}, 32'(host_rdata), 32'(e.data));
        checkOutput({tag, "_wrindex"}, 32'(wr_index), 32'(e.idx));
      end
    end
  endtask

  task automatic endCycle(input string tag);
    int n;
    negateBus();
    n = 0;
    while (n < 20 && (nDTACK_OE || nBERR_OE)) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput({tag, "_released"}, 32'(nDTACK_OE | nBERR_OE), 32'd0);
    checkOutput({tag, "_doe_cleared"}, 32'(D_OE), 32'd0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic doAccess(input string tag, input logic [23:0] addr, input logic rnw, input logic uds,
                          input logic lds, input logic [15:0] data, output logic [15:0] hostBefore);
    int cycles;
    int s0;
    logic held;
    logic [15:0] oeExp;
    oeExp = {{8{uds}}, {8{lds}}};
    s0 = strobeCount;
    applyStimulus(addr, rnw, uds, lds, data);
    waitAck(cycles, hostBefore);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(ACK_LAT));
    if (rnw) begin
      popCheck(tag);
      held = 1'b1;
      repeat (3) begin
        @(negedge sys_clk);
        if (!(nDTACK_OE === 1'b1 && D_OE === oeExp)) held = 1'b0;
      end
      checkOutput({tag, "_held"}, 32'(held), 32'd1);
    end
    endCycle(tag);
    if (!rnw) begin
      popCheck(tag);
      checkOutput({tag, "_strobes"}, 32'(strobeCount - s0), 32'd1);
    end
  endtask

  initial begin
    int cycles;
    int s0;
    logic quiet;
    logic [15:0] hb;

    for (int i = 0; i < 7; i++) model[i] = 16'h0000;
    model[7] = 16'h5016;

    sys_rst   = 1'b1;
    A_IN      = '0;
    D_IN      = '0;
    RnW_IN    = 1'b1;
    nAS_IN    = 1'b1;
    nUDS_IN   = 1'b1;
    nLDS_IN   = 1'b1;
    host_addr = '0;

    repeat (3) @(negedge sys_clk);
    checkOutput("rst_dtack", 32'(nDTACK_OE), 32'd0);
    checkOutput("rst_berr", 32'(nBERR_OE), 32'd0);
    checkOutput("rst_doe", 32'(D_OE), 32'd0);
    checkOutput("rst_dout", 32'(D_OUT), 32'd0);
    checkOutput("rst_wrstrobe", 32'(wr_strobe), 32'd0);
    checkOutput("rst_wrindex", 32'(wr_index), 32'd0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
    host_addr = 3'd0;
    #1 checkOutput("rst_reg0", 32'(host_rdata), 32'h0000);
    host_addr = 3'd7;
    #1 checkOutput("rst_reg7", 32'(host_rdata), 32'h5016);

    $display("[TB] word write to register 1");
    host_addr = 3'd1;
    doAccess("w_word_r1", BASE + 24'd2, 1'b0, 1'b1, 1'b1, 16'hA55A, hb);
    checkOutput("r1_old_before_write", 32'(hb), 32'h0000);

    $display("[TB] byte lane writes");
    doAccess("w_word_r2", BASE + 24'd4, 1'b0, 1'b1, 1'b1, 16'h3344, hb);
    doAccess("w_upper_r2", BASE + 24'd4, 1'b0, 1'b1, 1'b0, 16'h12FF, hb);
    doAccess("w_lower_r3", BASE + 24'd6, 1'b0, 1'b0, 1'b1, 16'hBEEF, hb);

    $display("[TB] reads");
    doAccess("r_word_r7", BASE + 24'd14, 1'b1, 1'b1, 1'b1, 16'h0000, hb);
    doAccess("r_lower_r1", BASE + 24'd2, 1'b1, 1'b0, 1'b1, 16'h0000, hb);

    $display("[TB] access outside the window");
    s0 = strobeCount;
    driveBus(BASE + 24'd16, 1'b0, 1'b1, 1'b1, 16'h7777);
    quiet = 1'b1;
    repeat (12) begin
      @(negedge sys_clk);
      if (nDTACK_OE || nBERR_OE || D_OE != 16'h0000 || wr_strobe) quiet = 1'b0;
    end
    checkOutput("outside_quiet", 32'(quiet), 32'd1);
    negateBus();
    repeat (4) @(negedge sys_clk);
    checkOutput("outside_strobes", 32'(strobeCount - s0), 32'd0);
    host_addr = 3'd0;
    #1 checkOutput("outside_reg0", 32'(host_rdata), 32'(model[0]));

    $display("[TB] write to read-only register 7");
    s0 = strobeCount;
    driveBus(BASE + 24'd14, 1'b0, 1'b1, 1'b1, 16'hFFFF);
    waitAck(cycles, hb);
    checkOutput("w_r7_latency", 32'(cycles), 32'(ACK_LAT));
`ifdef MC68K_TARGET_BERR_EN
    checkOutput("w_r7_berr", 32'(nBERR_OE), 32'd1);
    checkOutput("w_r7_dtack", 32'(nDTACK_OE), 32'd0);
`else
    checkOutput("w_r7_dtack", 32'(nDTACK_OE), 32'd1);
    checkOutput("w_r7_berr", 32'(nBERR_OE), 32'd0);
`endif
    endCycle("w_r7");
    checkOutput("w_r7_strobes", 32'(strobeCount - s0), 32'd0);
    host_addr = 3'd7;
    #1 checkOutput("w_r7_value", 32'(host_rdata), 32'h5016);

    doAccess("r_upper_r2", BASE + 24'd4, 1'b1, 1'b1, 1'b0, 16'h0000, hb);

    $display("[TB] reset during the delay phase of a write");
    driveBus(BASE + 24'd8, 1'b0, 1'b1, 1'b1, 16'h1111);
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 7; i++) model[i] = 16'h0000;
    s0 = strobeCount;
    quiet = 1'b1;
    repeat (15) begin
      @(negedge sys_clk);
      if (nDTACK_OE || nBERR_OE || D_OE != 16'h0000 || wr_strobe) quiet = 1'b0;
    end
    checkOutput("midrst_quiet", 32'(quiet), 32'd1);
    checkOutput("midrst_strobes", 32'(strobeCount - s0), 32'd0);
    checkOutput("midrst_dout", 32'(D_OUT), 32'd0);
    checkOutput("midrst_wrindex", 32'(wr_index), 32'd0);
    host_addr = 3'd4;
    #1 checkOutput("midrst_reg4", 32'(host_rdata), 32'h0000);
    host_addr = 3'd1;
    #1 checkOutput("midrst_reg1", 32'(host_rdata), 32'h0000);
    negateBus();
    repeat (5) @(negedge sys_clk);

    doAccess("w_after_rst_r4", BASE + 24'd8, 1'b0, 1'b1, 1'b1, 16'h2222, hb);
    doAccess("r_word_r4", BASE + 24'd8, 1'b1, 1'b1, 1'b1, 16'h0000, hb);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mc68k_bus_target.md
MC68K_BUS_TARGET -- requirements
Module: mc68k_bus_target

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 24'hE90000: 24-bit base of the 16-byte target window, bits [3:0] ignored.
REQ-002 SHALL provide parameter DTACK_DELAY, default 2: sys_clk cycles from cycle acceptance to DTACK assertion, legal range 1..15.
REQ-003 SHALL use one clock and a synchronous active-high reset; ports are listed clock and reset first:
  sys_clk  in  1  system clock, all logic on rising edge
  sys_rst  in  1  synchronous reset, active high
  A_IN  in  23  68k address bus A[23:1]
  D_IN  in  16  68k data bus
  RnW_IN  in  1  68k read/write, 1 = read
  nAS_IN, nUDS_IN, nLDS_IN  in  1 each  68k strobes, active low
  D_OUT  out  16  read data
  D_OE  out  16  per-bit data drive enable, 1 = drive
  nDTACK_OE  out  1  1 = pull nDTACK low
  nBERR_OE  out  1  1 = pull nBERR low (see REQ-020)
  host_addr  in  3  local register read index
  host_rdata  out  16  combinational register[host_addr]
  wr_strobe  out  1  one-cycle pulse per accepted bus write
  wr_index  out  3  register index of last bus write

Function
REQ-004 SHALL pass A_IN, RnW_IN, nAS_IN, nUDS_IN, nLDS_IN and D_IN through a 2-flop synchronizer before any use.
REQ-005 SHALL implement states IDLE, ACCEPT, DELAY, ACK, RELEASE.
REQ-006 IDLE: on synced nAS low and at least one synced DS low, latch A[23:1], RnW, UDS, LDS; if A[23:4] equals BASE_ADDR[23:4], go to ACCEPT, else go to RELEASE without driving anything.
REQ-007 ACCEPT: load the delay counter with DTACK_DELAY-1, go to DELAY; the register index is latched A[3:1].
REQ-008 DELAY: decrement the counter; at zero, perform the access and go to ACK.
REQ-009 Write access: UDS writes D_IN[15:8] into reg[index][15:8]; LDS writes D_IN[7:0] into [7:0]; unselected lanes are unchanged; wr_strobe pulses exactly one cycle and wr_index is updated.
REQ-010 Read access: D_OUT is set to reg[index]; D_OE[15:8] is set by UDS and D_OE[7:0] by LDS.
REQ-011 ACK: nDTACK_OE=1 and D_OE are held until synced nAS, nUDS and nLDS are all high, then all drives are cleared in the same cycle and the state returns to IDLE.
REQ-012 RELEASE: no drives are active; the state returns to IDLE once synced nAS is high.
REQ-013 Registers 0..6 are read/write; register 7 is read-only with constant value 16'h5016, and a bus write to it SHALL NOT change it or pulse wr_strobe.
REQ-014 A host_rdata read on the same cycle as a bus write to the same index SHALL return the old value.
REQ-015 Latency: nDTACK_OE rises DTACK_DELAY+1 cycles after the IDLE acceptance cycle.
REQ-016 Only one bus cycle SHALL be processed at a time; a new cycle requires nAS high to have been observed first.

Reset
REQ-017 sys_rst SHALL force state IDLE, registers 0..6 to 16'h0000, D_OUT to 0, D_OE to 0, nDTACK_OE to 0, nBERR_OE to 0, wr_strobe to 0, wr_index to 0, and the counter to 0.
REQ-018 If nAS is low when reset deasserts, or reset hits mid-cycle, the block SHALL enter RELEASE and ignore that bus cycle.
REQ-019 Synchronizer flops SHALL reset to the inactive level: strobes to 1, everything else to 0.

Configuration
REQ-020 Macro MC68K_TARGET_BERR_EN:
  - Defined: a write to register 7 asserts nBERR_OE instead of nDTACK_OE, with the same timing and release rule as REQ-011.
  - Undefined: such a write is acknowledged with DTACK and ignored; nBERR_OE is tied to 0.

Verification
REQ-021 Word write 16'hA55A to BASE_ADDR+2, UDS and LDS both low -> reg1=16'hA55A, wr_strobe one pulse, wr_index=1, nDTACK_OE high 3 cycles after acceptance.
REQ-022 Byte write 16'h12FF with only UDS to BASE_ADDR+4, where reg2 was 16'h3344 -> reg2=16'h1244.
REQ-023 Word read of BASE_ADDR+14 -> D_OUT=16'h5016, D_OE=16'hFFFF held until nAS/nDS negate, then released the next cycle with nDTACK_OE.
REQ-024 Access to BASE_ADDR+16 -> no D_OE, no nDTACK_OE, no nBERR_OE; returns to IDLE after nAS goes high.
REQ-025 Write to register 7 -> with MC68K_TARGET_BERR_EN, nBERR_OE=1 and nDTACK_OE=0; without it, nDTACK_OE=1; register 7 stays 16'h5016 in both cases.
REQ-026 sys_rst pulsed during DELAY of a write with nAS held low -> no write, no DTACK; the next cycle is accepted only after nAS goes high then low again.
